countdown_sequencer: RTL and testbench

- Control block for the game's seconds display. Runs a two-digit BCD countdown from a loaded preset, with load, start, pause/resume, clear and expiry sequencing.
- Generates its own 1 Hz tick enable from the 50 MHz board clock. No derived clock.
- Drives the 7-segment decoders and raises a `done` strobe for the game FSM.

---
 rtl/timer_pkg.sv | 22 ++
 rtl/tick_prescaler.sv | 41 ++++
 rtl/countdown_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_countdown_sequencer.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// -----------------------------------------------------------------------------
// timer_pkg
// Shared types for the seconds-display countdown timer.
//   state_t : sequencer states (IDLE, LOADED, RUN, PAUSE, EXPIRED), 3 bits
//   bcd_t   : one BCD digit
//   BCD_MAX : largest legal BCD digit value
// -----------------------------------------------------------------------------
package timer_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      LOADED  = 3'd1,
      RUN     = 3'd2,
      PAUSE   = 3'd3,
      EXPIRED = 3'd4
   } state_t;

   typedef logic [3:0] bcd_t;

   localparam bcd_t BCD_MAX = 4'd9;

endpackage

// File: rtl/tick_prescaler.sv
// -----------------------------------------------------------------------------
// tick_prescaler
// Divides the board clock down to a one-cycle tick enable every TICK_DIV
// enabled cycles. The count holds while en is low, so a paused countdown
// keeps its fractional second.
//   clk   : board clock
//   reset : asynchronous, active-low reset
//   clr   : synchronous clear of the count (wins over en)
//   en    : count enable
//   tick  : high on the enabled cycle where the count wraps
// Parameter TICK_DIV : enabled cycles per tick.
// -----------------------------------------------------------------------------
module tick_prescaler #(
   parameter int TICK_DIV = 50_000_000
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic tick
);

   localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] count_reg;

   // Combinational so the decrement lands on the same edge as the wrap.
   assign tick = en && (count_reg == LAST);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_reg <= '0;
      end else if (clr || tick) begin
         count_reg <= '0;
      end else if (en) begin
         count_reg <= count_reg + CW'(1);
      end
   end

endmodule

// File: rtl/countdown_sequencer.sv
// -----------------------------------------------------------------------------
// countdown_sequencer
// Two-digit BCD seconds countdown with load / start / pause / clear and expiry
// sequencing for the game's seconds display.
//   clk          : 50 MHz board clock
//   reset        : asynchronous, active-low reset
//   load         : pulse, latch preset digits (IDLE, LOADED, EXPIRED only)
//   preset_ones  : BCD ones digit of the preset
//   preset_tens  : BCD tens digit of the preset
//   start        : pulse, begin counting (LOADED only)
//   pause        : pulse, toggle RUN / PAUSE
//   clear        : pulse, abort to IDLE with digits 00
//   one_digits   : current ones digit
//   ten_digits   : current tens digit
//   running      : high in RUN
//   paused       : high in PAUSE
//   expired      : high in EXPIRED
//   done         : one-cycle pulse when the count reaches 00
//   warn         : (TIMER_WARN_EN only) remaining 1..WARN_SECS while RUN/PAUSE
// Build option: define TIMER_WARN_EN to add the warn output.
// Control priority within a cycle: clear > load > start > pause.
// -----------------------------------------------------------------------------
module countdown_sequencer
   import timer_pkg::*;
#(
   parameter int TICK_DIV  = 50_000_000,
   parameter int MAX_TENS  = 9,
   parameter int WARN_SECS = 5
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       load,
   input  logic [3:0] preset_ones,
   input  logic [3:0] preset_tens,
   input  logic       start,
   input  logic       pause,
   input  logic       clear,
   output logic [3:0] one_digits,
   output logic [3:0] ten_digits,
   output logic       running,
   output logic       paused,
   output logic       expired,
   output logic       done
`ifdef TIMER_WARN_EN
   ,
   output logic       warn
`endif
);

   // Tens limit never exceeds a legal BCD digit.
   localparam bcd_t TENS_LIMIT = (MAX_TENS >= 9) ? BCD_MAX :
                                 (MAX_TENS <= 0) ? 4'd0 : bcd_t'(MAX_TENS);

   state_t state_reg, state_next;
   bcd_t   ones_reg, ones_next;
   bcd_t   tens_reg, tens_next;
   logic   done_reg, done_next;
   logic   presc_clr, presc_en, tick;

   // ---------------- preset clamping (index 0 = ones, 1 = tens) -------------
   bcd_t preset_raw     [2];
   bcd_t preset_clamped [2];

   assign preset_raw[0] = preset_ones;
   assign preset_raw[1] = preset_tens;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_clamp
         localparam bcd_t LIMIT = (gi == 1) ? TENS_LIMIT : BCD_MAX;
         assign preset_clamped[gi] = (preset_raw[gi] > LIMIT) ? LIMIT : preset_raw[gi];
      end
   endgenerate

   // ---------------- one-second prescaler -----------------------------------
   assign presc_en = (state_reg == RUN);

   tick_prescaler #(
      .TICK_DIV (TICK_DIV)
   ) u_prescaler (
      .clk   (clk),
      .reset (reset),
      .clr   (presc_clr),
      .en    (presc_en),
      .tick  (tick)
   );

   // ---------------- BCD decrement ------------------------------------------
   bcd_t dec_ones, dec_tens;
   logic at_one;

   assign dec_ones = (ones_reg == 4'd0) ? BCD_MAX : ones_reg - 4'd1;
   assign dec_tens = (ones_reg == 4'd0) ? tens_reg - 4'd1 : tens_reg;
   // Next tick lands on 00; used to stop there instead of wrapping to 99.
   assign at_one   = (tens_reg == 4'd0) && (ones_reg == 4'd1);

   // ---------------- state / datapath register ------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg <= IDLE;
         ones_reg  <= 4'd0;
         tens_reg  <= 4'd0;
         done_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         ones_reg  <= ones_next;
         tens_reg  <= tens_next;
         done_reg  <= done_next;
      end
   end

   // ---------------- next state ---------------------------------------------
   always_comb begin
      state_next = state_reg;
      ones_next  = ones_reg;
      tens_next  = tens_reg;
      done_next  = 1'b0;
      presc_clr  = 1'b0;

      if (clear) begin
         state_next = IDLE;
         ones_next  = 4'd0;
         tens_next  = 4'd0;
         presc_clr  = 1'b1;
      end else if (load && (state_reg == IDLE || state_reg == LOADED ||
                            state_reg == EXPIRED)) begin
         state_next = LOADED;
         ones_next  = preset_clamped[0];
         tens_next  = preset_clamped[1];
      end else if (start && state_reg == LOADED) begin
         if (ones_reg == 4'd0 && tens_reg == 4'd0) begin
            state_next = EXPIRED;
            done_next  = 1'b1;
         end else begin
            state_next = RUN;
            presc_clr  = 1'b1;
         end
      end else if (tick) begin
         // tick implies RUN. A coincident pause still enters PAUSE after the
         // decrement, unless the decrement expires the count.
         ones_next = dec_ones;
         tens_next = dec_tens;
         if (at_one) begin
            state_next = EXPIRED;
            done_next  = 1'b1;
         end else if (pause) begin
            state_next = PAUSE;
         end
      end else if (pause) begin
         if (state_reg == RUN) begin
            state_next = PAUSE;
         end else if (state_reg == PAUSE) begin
            state_next = RUN;
         end
      end
   end

   // ---------------- outputs ------------------------------------------------
   always_comb begin
      running    = (state_reg == RUN);
      paused     = (state_reg == PAUSE);
      expired    = (state_reg == EXPIRED);
      done       = done_reg;
      one_digits = ones_reg;
      ten_digits = tens_reg;
   end

`ifdef TIMER_WARN_EN
   // Registered from next-state values so warn moves with the digits.
   logic warn_reg, warn_next;
   int   secs_next;

   always_comb begin
      secs_next = 10 * int'(tens_next) + int'(ones_next);
      warn_next = (state_next == RUN || state_next == PAUSE) &&
                  (secs_next <= WARN_SECS) && (secs_next != 0);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         warn_reg <= 1'b0;
      end else begin
         warn_reg <= warn_next;
      end
   end

   assign warn = warn_reg;
`endif

endmodule

// File: tb/tb_countdown_sequencer.sv
// -----------------------------------------------------------------------------
// tb_countdown_sequencer
// Self-checking bench for countdown_sequencer with TICK_DIV = 4: a directed
// vector table, hand-written multi-cycle sequences, and a randomized run
// compared against a seconds-level reference model.
// -----------------------------------------------------------------------------
module tb_countdown_sequencer;

   localparam int TD = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       load = 1'b0, start = 1'b0, pause = 1'b0, clear = 1'b0;
   logic [3:0] preset_ones = 4'd0, preset_tens = 4'd0;
   logic [3:0] one_digits, ten_digits;
   logic       running, paused, expired, done;
`ifdef TIMER_WARN_EN
   logic       warn;
`endif

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   countdown_sequencer #(
      .TICK_DIV  (TD),
      .MAX_TENS  (9),
      .WARN_SECS (5)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .load        (load),
      .preset_ones (preset_ones),
      .preset_tens (preset_tens),
      .start       (start),
      .pause       (pause),
      .clear       (clear),
      .one_digits  (one_digits),
      .ten_digits  (ten_digits),
      .running     (running),
      .paused      (paused),
      .expired     (expired),
      .done        (done)
`ifdef TIMER_WARN_EN
      ,
      .warn        (warn)
`endif
   );

   // Outputs packed as {tens, ones, running, paused, expired, done}.
   function automatic logic [11:0] outs();
      return {ten_digits, one_digits, running, paused, expired, done};
   endfunction

   function automatic logic [11:0] ev(input int t, input int o, input logic r,
                                      input logic p, input logic e, input logic d);
      return {4'(t), 4'(o), r, p, e, d};
   endfunction

   task automatic check(input string name, input logic [11:0] exp, input bit verbose);
      logic [11:0] act;
      act = outs();
      n_checks++;
      if (act === exp) begin
         n_pass++;
         if (verbose)
            $display("%-16s digits=%0d%0d run=%b pau=%b exp=%b done=%b ok",
                     name, act[11:8], act[7:4], act[3], act[2], act[1], act[0]);
      end else begin
         $display("FAIL %s: got digits=%0d%0d run=%b pau=%b exp=%b done=%b, required digits=%0d%0d run=%b pau=%b exp=%b done=%b",
                  name, act[11:8], act[7:4], act[3], act[2], act[1], act[0],
                  exp[11:8], exp[7:4], exp[3], exp[2], exp[1], exp[0]);
      end
   endtask

   // Apply one cycle of control inputs; returns #1 after the clock edge.
   task automatic step(input logic c, input logic l, input logic s, input logic p,
                       input logic [3:0] t, input logic [3:0] o);
      clear = c; load = l; start = s; pause = p;
      preset_tens = t; preset_ones = o;
      @(posedge clk);
      #1;
      clear = 1'b0; load = 1'b0; start = 1'b0; pause = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
   endtask

   task automatic do_reset();
      #2 reset = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #3 reset = 1'b1;
      @(negedge clk);
   endtask

   // ---------------- directed vector table -----------------------------------
   typedef struct {
      logic       c, l, s, p;
      logic [3:0] t, o;
      logic [11:0] exp;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input logic c, input logic l, input logic s, input logic p,
                               input logic [3:0] t, input logic [3:0] o,
                               input logic [11:0] exp);
      vec_t v;
      v.c = c; v.l = l; v.s = s; v.p = p; v.t = t; v.o = o; v.exp = exp;
      return v;
   endfunction

   // ---------------- reference model (whole seconds + fraction) --------------
   localparam int M_IDLE = 0, M_LOADED = 1, M_RUN = 2, M_PAUSE = 3, M_EXP = 4;
   int m_mode, m_secs, m_frac;
   bit m_done;

   function automatic int clamp9(input int d);
      return (d > 9) ? 9 : d;
   endfunction

   task automatic model_step(input bit c, input bit l, input bit s, input bit p,
                             input int t, input int o);
      m_done = 1'b0;
      if (c) begin
         m_mode = M_IDLE; m_secs = 0; m_frac = 0;
      end else if (l && (m_mode == M_IDLE || m_mode == M_LOADED || m_mode == M_EXP)) begin
         m_mode = M_LOADED;
         m_secs = 10 * clamp9(t) + clamp9(o);
      end else if (s && m_mode == M_LOADED) begin
         if (m_secs == 0) begin
            m_mode = M_EXP; m_done = 1'b1;
         end else begin
            m_mode = M_RUN; m_frac = 0;
         end
      end else if (m_mode == M_RUN) begin
         m_frac = (m_frac + 1) % TD;
         if (m_frac == 0) m_secs = m_secs - 1;
         if (m_frac == 0 && m_secs == 0) begin
            m_mode = M_EXP; m_done = 1'b1;
         end else if (p) begin
            m_mode = M_PAUSE;
         end
      end else if (m_mode == M_PAUSE && p) begin
         m_mode = M_RUN;
      end
   endtask

   function automatic logic [11:0] model_out();
      return ev(m_secs / 10, m_secs % 10, m_mode == M_RUN, m_mode == M_PAUSE,
                m_mode == M_EXP, m_done);
   endfunction

   // ---------------- main sequence -------------------------------------------
   initial begin
      // Table: applied in order straight after reset.
      tbl.push_back(mk(0,0,0,0, 4'h0, 4'h0, ev(0,0,0,0,0,0)));
      tbl.push_back(mk(0,1,0,0, 4'hA, 4'hC, ev(9,9,0,0,0,0)));
      tbl.push_back(mk(0,0,0,1, 4'h0, 4'h0, ev(9,9,0,0,0,0)));
      tbl.push_back(mk(0,0,1,0, 4'h0, 4'h0, ev(9,9,1,0,0,0)));
      tbl.push_back(mk(0,0,0,0, 4'h0, 4'h0, ev(9,9,1,0,0,0)));
      tbl.push_back(mk(0,0,0,0, 4'h0, 4'h0, ev(9,9,1,0,0,0)));
      tbl.push_back(mk(0,0,0,0, 4'h0, 4'h0, ev(9,9,1,0,0,0)));
      tbl.push_back(mk(0,0,0,0, 4'h0, 4'h0, ev(9,8,1,0,0,0)));
      tbl.push_back(mk(0,1,0,0, 4'h1, 4'h2, ev(9,8,1,0,0,0)));
      tbl.push_back(mk(1,1,0,1, 4'h5, 4'h5, ev(0,0,0,0,0,0)));
      tbl.push_back(mk(0,0,1,0, 4'h0, 4'h0, ev(0,0,0,0,0,0)));
      tbl.push_back(mk(0,1,0,0, 4'h0, 4'h0, ev(0,0,0,0,0,0)));
      tbl.push_back(mk(0,0,1,0, 4'h0, 4'h0, ev(0,0,0,0,1,1)));
      tbl.push_back(mk(0,0,0,0, 4'h0, 4'h0, ev(0,0,0,0,1,0)));
      tbl.push_back(mk(0,0,1,0, 4'h0, 4'h0, ev(0,0,0,0,1,0)));
      tbl.push_back(mk(0,0,0,1, 4'h0, 4'h0, ev(0,0,0,0,1,0)));
      tbl.push_back(mk(0,1,0,0, 4'h0, 4'h1, ev(0,1,0,0,0,0)));
      tbl.push_back(mk(0,0,1,0, 4'h0, 4'h0, ev(0,1,1,0,0,0)));
      tbl.push_back(mk(0,0,0,0, 4'h0, 4'h0, ev(0,1,1,0,0,0)));
      tbl.push_back(mk(0,0,0,0, 4'h0, 4'h0, ev(0,1,1,0,0,0)));
      tbl.push_back(mk(0,0,0,0, 4'h0, 4'h0, ev(0,1,1,0,0,0)));
      tbl.push_back(mk(0,0,0,0, 4'h0, 4'h0, ev(0,0,0,0,1,1)));
      tbl.push_back(mk(0,0,0,0, 4'h0, 4'h0, ev(0,0,0,0,1,0)));

      // Reset state.
      #3;
      check("reset_state", ev(0,0,0,0,0,0), 1'b1);
      do_reset();

      foreach (tbl[i]) begin
         step(tbl[i].c, tbl[i].l, tbl[i].s, tbl[i].p, tbl[i].t, tbl[i].o);
         check($sformatf("vec_%0d", i), tbl[i].exp, 1'b1);
      end

      // 12 -> 00: first decrement at +4, 09 at +12, expiry at +48.
      do_reset();
      step(0,1,0,0, 4'd1, 4'd2);
      check("a_load12", ev(1,2,0,0,0,0), 1'b1);
      step(0,0,1,0, 4'd0, 4'd0);
      check("a_start", ev(1,2,1,0,0,0), 1'b1);
      for (int k = 1; k <= 50; k++) begin
         idle(1);
         if (k == 3)  check("a_plus3",  ev(1,2,1,0,0,0), 1'b1);
         if (k == 4)  check("a_plus4",  ev(1,1,1,0,0,0), 1'b1);
         if (k == 12) check("a_plus12", ev(0,9,1,0,0,0), 1'b1);
         if (k == 47) check("a_plus47", ev(0,1,1,0,0,0), 1'b1);
         if (k == 48) check("a_plus48", ev(0,0,0,0,1,1), 1'b1);
         if (k == 49) check("a_plus49", ev(0,0,0,0,1,0), 1'b1);
         if (k == 50) check("a_plus50", ev(0,0,0,0,1,0), 1'b1);
      end

      // Pause at 07 with two cycles of the second already elapsed.
      do_reset();
      step(0,1,0,0, 4'd0, 4'd8);
      step(0,0,1,0, 4'd0, 4'd0);
      idle(4);
      check("b_at07", ev(0,7,1,0,0,0), 1'b1);
      idle(2);
      step(0,0,0,1, 4'd0, 4'd0);
      check("b_pause", ev(0,7,0,1,0,0), 1'b1);
      for (int k = 0; k < 20; k++) begin
         idle(1);
         check($sformatf("b_hold_%0d", k), ev(0,7,0,1,0,0), 1'b0);
      end
      step(0,0,0,1, 4'd0, 4'd0);
      check("b_resume", ev(0,7,1,0,0,0), 1'b1);
      idle(1);
      check("b_remainder", ev(0,6,1,0,0,0), 1'b1);

      // Asynchronous reset mid-RUN at 05, checked between clock edges.
      do_reset();
      step(0,1,0,0, 4'd0, 4'd7);
      step(0,0,1,0, 4'd0, 4'd0);
      idle(8);
      check("c_at05", ev(0,5,1,0,0,0), 1'b1);
      #2 reset = 1'b0;
      #1;
      check("c_async_reset", ev(0,0,0,0,0,0), 1'b1);
      #2 reset = 1'b1;
      step(0,0,1,0, 4'd0, 4'd0);
      check("c_start_ignored", ev(0,0,0,0,0,0), 1'b1);
      step(0,1,0,0, 4'd0, 4'd3);
      step(0,0,1,0, 4'd0, 4'd0);
      check("c_reload_start", ev(0,3,1,0,0,0), 1'b1);

      // clear + load + pause together in RUN at 30.
      do_reset();
      step(0,1,0,0, 4'd3, 4'd0);
      step(0,0,1,0, 4'd0, 4'd0);
      idle(1);
      check("d_at30", ev(3,0,1,0,0,0), 1'b1);
      step(1,1,0,1, 4'd5, 4'd5);
      check("d_clear_wins", ev(0,0,0,0,0,0), 1'b1);
      step(0,0,1,0, 4'd0, 4'd0);
      check("d_not_loaded", ev(0,0,0,0,0,0), 1'b1);

      // Randomized run against the reference model.
      do_reset();
      m_mode = M_IDLE; m_secs = 0; m_frac = 0; m_done = 1'b0;
      for (int n = 0; n < 3000; n++) begin
         bit c, l, s, p;
         int kind, t, o;
         c    = ($urandom_range(0, 99) < 2);
         kind = $urandom_range(0, 99);
         l    = (kind < 8);
         s    = (kind >= 8 && kind < 20);
         p    = (kind >= 20 && kind < 28);
         t    = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 1);
         o    = $urandom_range(0, 15);
         model_step(c, l, s, p, t, o);
         step(c, l, s, p, 4'(t), 4'(o));
         check($sformatf("rand_%0d", n), model_out(), 1'b0);
      end
      $display("random phase: %0d cycles compared", 3000);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
      $fatal(1, "watchdog");
   end

endmodule
